execute_stage: RTL
==================

EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 Parameter XLEN, default 32: datapath width in bits; legal values 8..64.
REQ-002 Parameter RA_W, default 5: register-address width.
REQ-003 Parameter CTRL_W, default 4: ALU control width.
REQ-004 Port clk  in  1: single clock; all state updates on its rising edge.
REQ-005 Port rst  in  1: reset, asynchronous and active-high.
REQ-006 Port in_valid  in  1 / in_ready  out  1: upstream handshake; a transfer occurs when both are high on a clk edge.
REQ-007 Ports reg_write_i, mem_to_reg_i, mem_write_i  in  1 each: control bits carried through the stage.
REQ-008 Port alu_ctrl  in  CTRL_W: operation select. Port alu_src  in  1: selects B = imm. Port reg_dst  in  1: selects destination = rd.
REQ-009 Ports rt, rd  in  RA_W: candidate destination registers.
REQ-010 Ports value1, value2, imm  in  XLEN each: register-file operands and sign-extended immediate.
REQ-011 Ports fwd_a, fwd_b  in  2 each: operand forward select (0 = regfile, 1 = fwd_mem, 2 = fwd_wb, 3 = regfile).
REQ-012 Ports fwd_mem, fwd_wb  in  XLEN each: forwarded results from later stages.
REQ-013 Port out_valid  out  1 / out_ready  in  1: downstream handshake.
REQ-014 Ports reg_write_o, mem_to_reg_o, mem_write_o  out  1; write_reg  out  RA_W; alu_out  out  XLEN; write_data  out  XLEN: registered results.
REQ-015 Port busy  out  1: multi-cycle operation in progress.

Function
REQ-016 At accept: A = value1/fwd_mem/fwd_wb per fwd_a; Bfwd likewise per fwd_b; B = imm if alu_src else Bfwd; write_data captured = Bfwd; write_reg captured = rd if reg_dst else rt; control bits captured unchanged.
REQ-017 Forwarding inputs are sampled only in the accept cycle; later changes do not affect the result.
REQ-018 alu_ctrl encodings: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed, result 1/0), 6 SLL, 7 SRL, 8 SRA, 9 MUL; all others yield alu_out = 0.
REQ-019 Shift amount = B[$clog2(XLEN)-1:0]; ADD/SUB/MUL wrap modulo 2^XLEN, no overflow flag.
REQ-020 Single-cycle ops: outputs valid one cycle after accept (out_valid rises on the accept edge).
REQ-021 in_ready = !busy && (!out_valid || out_ready); accept and drain in the same cycle is permitted (full throughput).
REQ-022 While out_valid && !out_ready, all outputs hold stable.
REQ-023 out_valid clears on a drain edge unless a new accept happens on the same edge.
REQ-024 FSM states: IDLE (no work/output held), MUL (iterating), DONE folded into out_valid; IDLE->MUL on accept of op 9 when mul enabled; MUL->IDLE after XLEN iterations with out_valid set.
REQ-025 In MUL: busy = 1, out_valid = 0, in_ready = 0; one shift-add iteration per cycle; result = low XLEN bits of A*B; total latency XLEN+1 cycles from accept to out_valid.
REQ-026 A MUL may be accepted on the same edge that drains a previous result.

Reset
REQ-027 rst high asynchronously forces: out_valid 0, busy 0, FSM IDLE, iteration counter 0, all output registers 0 (alu_out, write_data, write_reg, control bits).
REQ-028 rst asserted mid-MUL aborts the operation; no result is ever presented for it.
REQ-029 in_ready is 1 on the first edge after rst deasserts.

Configuration
REQ-030 Macro EX_MUL_EN: when defined, the iterative multiplier and MUL state are compiled in per REQ-024/025.
REQ-031 Without EX_MUL_EN: alu_ctrl 9 is treated as undefined (alu_out = 0, single-cycle), busy is tied 0, no multiplier logic exists.

Verification
REQ-032 XLEN=32, value1=5, value2=7, alu_ctrl=0, fwd 0/0, out_ready=1 -> alu_out=12 one cycle after accept, write_reg=rt.
REQ-033 fwd_a=1, fwd_mem=100, fwd_b=2, fwd_wb=3, alu_ctrl=1 -> alu_out=97, write_data=3; alu_src=1, imm=-1, alu_ctrl=5 with A=-2 -> alu_out=1.
REQ-034 Back-to-back ADDs with out_ready low for 3 cycles -> first result held stable, in_ready=0, no loss; on release each result appears once in order.
REQ-035 EX_MUL_EN defined, A=0xFFFF_FFFF, B=3, alu_ctrl=9 -> busy high 32 cycles, out_valid after 33, alu_out=0xFFFF_FFFD.
REQ-036 rst pulsed at iteration 10 of a MUL -> out_valid and busy 0 immediately, no result emitted, next ADD completes normally.
REQ-037 EX_MUL_EN undefined, alu_ctrl=9 -> alu_out=0 after one cycle, busy never asserts.

Source files
------------

// File: rtl/execute_stage.sv
// Pipeline execute stage: operand forwarding, ALU and a registered valid/ready output slot.
// Define EX_MUL_EN to compile in the iterative shift-add multiplier for alu_ctrl 9.

module execute_stage #(
  parameter int XLEN   = 32,
  parameter int RA_W   = 5,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              reg_write_i,
  input  logic              mem_to_reg_i,
  input  logic              mem_write_i,
  input  logic [CTRL_W-1:0] alu_ctrl,
  input  logic              alu_src,
  input  logic              reg_dst,
  input  logic [RA_W-1:0]   rt,
  input  logic [RA_W-1:0]   rd,
  input  logic [XLEN-1:0]   value1,
  input  logic [XLEN-1:0]   value2,
  input  logic [XLEN-1:0]   imm,
  input  logic [1:0]        fwd_a,
  input  logic [1:0]        fwd_b,
  input  logic [XLEN-1:0]   fwd_mem,
  input  logic [XLEN-1:0]   fwd_wb,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              reg_write_o,
  output logic              mem_to_reg_o,
  output logic              mem_write_o,
  output logic [RA_W-1:0]   write_reg,
  output logic [XLEN-1:0]   alu_out,
  output logic [XLEN-1:0]   write_data,
  output logic              busy
);

  localparam int SH_W = $clog2(XLEN);

  localparam logic [CTRL_W-1:0] OP_ADD = CTRL_W'(0);
  localparam logic [CTRL_W-1:0] OP_SUB = CTRL_W'(1);
  localparam logic [CTRL_W-1:0] OP_AND = CTRL_W'(2);
  localparam logic [CTRL_W-1:0] OP_OR  = CTRL_W'(3);
  localparam logic [CTRL_W-1:0] OP_XOR = CTRL_W'(4);
  localparam logic [CTRL_W-1:0] OP_SLT = CTRL_W'(5);
  localparam logic [CTRL_W-1:0] OP_SLL = CTRL_W'(6);
  localparam logic [CTRL_W-1:0] OP_SRL = CTRL_W'(7);
  localparam logic [CTRL_W-1:0] OP_SRA = CTRL_W'(8);
  localparam logic [CTRL_W-1:0] OP_MUL = CTRL_W'(9);

  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] b_fwd;
  logic [XLEN-1:0] op_b;
  logic            accept;
  logic            drain;
  logic            is_mul;
  logic            mul_done;
  logic [XLEN-1:0] mul_result;

  // Single-cycle operations; MUL is handled by the iterative unit, never here.
  function automatic logic [XLEN-1:0] alu_op(input logic [CTRL_W-1:0] ctrl,
                                             input logic [XLEN-1:0]   a,
                                             input logic [XLEN-1:0]   b);
    logic [SH_W-1:0] sh;
    sh     = b[SH_W-1:0];
    alu_op = '0;
    case (ctrl)
      OP_ADD:  alu_op = a + b;
      OP_SUB:  alu_op = a - b;
      OP_AND:  alu_op = a & b;
      OP_OR:   alu_op = a | b;
      OP_XOR:  alu_op = a ^ b;
      OP_SLT:  alu_op = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL:  alu_op = a << sh;
      OP_SRL:  alu_op = a >> sh;
      OP_SRA:  alu_op = $signed(a) >>> sh;
      default: alu_op = '0;
    endcase
  endfunction

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    op_a  = value1;
    b_fwd = value2;
    case (fwd_a)
      2'd1:    op_a = fwd_mem;
      2'd2:    op_a = fwd_wb;
      default: op_a = value1;
    endcase
    case (fwd_b)
      2'd1:    b_fwd = fwd_mem;
      2'd2:    b_fwd = fwd_wb;
      default: b_fwd = value2;
    endcase
    op_b = alu_src ? imm : b_fwd;
  end

  assign in_ready = !busy && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid && out_ready;

`ifdef EX_MUL_EN
  typedef enum logic {S_IDLE, S_MUL} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] mcand, mplier, acc, acc_next;
  logic [SH_W-1:0] iter;
  logic            mul_last;

  assign is_mul     = (alu_ctrl == OP_MUL);
  assign mul_last   = (iter == SH_W'(XLEN - 1));
  assign acc_next   = acc + (mplier[0] ? mcand : '0);
  assign busy       = (state_q == S_MUL);
  assign mul_done   = busy && mul_last;
  assign mul_result = acc_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && is_mul) state_d = S_MUL;
      S_MUL:   if (mul_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // One shift-add step per cycle: low XLEN bits of A*B after XLEN steps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      iter   <= '0;
    end else if (accept && is_mul) begin
      mcand  <= op_a;
      mplier <= op_b;
      acc    <= '0;
      iter   <= '0;
    end else if (busy) begin
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      acc    <= acc_next;
      iter   <= mul_last ? '0 : iter + 1'b1;
    end
  end
`else
  assign is_mul     = 1'b0;
  assign busy       = 1'b0;
  assign mul_done   = 1'b0;
  assign mul_result = '0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      alu_out      <= '0;
      write_data   <= '0;
      write_reg    <= '0;
      reg_write_o  <= 1'b0;
      mem_to_reg_o <= 1'b0;
      mem_write_o  <= 1'b0;
    end else if (accept) begin
      write_data   <= b_fwd;
      write_reg    <= reg_dst ? rd : rt;
      reg_write_o  <= reg_write_i;
      mem_to_reg_o <= mem_to_reg_i;
      mem_write_o  <= mem_write_i;
      // A MUL accept may drain the previous result; its own result arrives later.
      out_valid    <= !is_mul;
      if (!is_mul) alu_out <= alu_op(alu_ctrl, op_a, op_b);
    end else if (mul_done) begin
      alu_out   <= mul_result;
      out_valid <= 1'b1;
    end else if (drain) begin
      out_valid <= 1'b0;
    end
  end

endmodule
